// File: rtl/divide_constant_17.sv
// divide_constant_17: sequential restoring divider by the constant 17.
// Accepts an unsigned WIDTH-bit dividend over a valid/ready handshake and
// produces one quotient bit per clock. quotient, remainder and exact are
// presented with out_valid WIDTH cycles after the accepting edge. The result
// is held until the consumer takes it, and kept on the outputs afterwards
// until the next division overwrites it.
module divide_constant_17 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [4:0]       remainder,
    output logic             exact
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [5:0] DIVISOR = 6'd17;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] dvd_q,       dvd_d;
    logic [4:0]       rem_q,       rem_d;
    logic [WIDTH-1:0] quo_acc_q,   quo_acc_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [4:0]       remainder_q, remainder_d;
    logic             exact_q,     exact_d;

    // One restoring step. The partial remainder never exceeds 16 after a
    // step, so only its low five bits are stored; the trial value after
    // shifting in the next dividend bit needs six bits for the compare.
    logic [5:0]       trial;
    logic             trial_ge;
    logic [4:0]       rem_step;
    logic [WIDTH-1:0] quo_step;

    // Next-state and datapath computation for the handshake FSM and divider.
    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        rem_d       = rem_q;
        quo_acc_d   = quo_acc_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        exact_d     = exact_q;

        trial    = {rem_q, dvd_q[WIDTH-1]};
        trial_ge = (trial >= DIVISOR);
        rem_step = trial_ge ? 5'(trial - DIVISOR) : trial[4:0];
        quo_step = {quo_acc_q[WIDTH-2:0], trial_ge};

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dvd_d     = dividend;
                    rem_d     = '0;
                    quo_acc_d = '0;
                    cnt_d     = CNT_LAST;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                dvd_d     = {dvd_q[WIDTH-2:0], 1'b0};
                rem_d     = rem_step;
                quo_acc_d = quo_step;
                cnt_d     = CW'(cnt_q - 1'b1);
                if (cnt_q == '0) begin
                    quotient_d  = quo_step;
                    remainder_d = rem_step;
                    exact_d     = (rem_step == 5'd0);
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any division in progress immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dvd_q       <= '0;
            rem_q       <= '0;
            quo_acc_q   <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            exact_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            rem_q       <= rem_d;
            quo_acc_q   <= quo_acc_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            exact_q     <= exact_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign exact     = exact_q;

endmodule
